traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter YEL_MIN, default 3: minimum legal yellow dwell, in clk cycles.
REQ-002 Parameter MAX_RED, default 60: red dwell, in cycles, at which a road is flagged starved.
REQ-003 Parameter CNT_W, default 8: width of each per-road dwell counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 light_M1, light_S, light_MT, light_M2  input  3 each  light buses from the controller; red=3'b100, yellow=3'b010, green=3'b001.
REQ-007 clr  input  1  clears all sticky error bits.
REQ-008 err_sticky  output  5  latched flags {starve, seq, yel, conflict, enc}, bits [4:0].
REQ-009 err_pulse  output  1  high for one cycle when any flag event occurs.
REQ-010 cycle_cnt  output  16  count of completed M1 phase cycles.

Function
REQ-011 Each bus SHALL be sampled every cycle; each flag SHALL be registered and visible in the cycle after the sampling edge.
REQ-012 Any bus value other than the three legal codes SHALL set enc.
- That road's state and dwell hold.
- That road is excluded from sequence and conflict checks for that cycle.
REQ-013 Each road SHALL have an FSM with states UNKNOWN, GREEN, YELLOW and RED; reset state is UNKNOWN.
- From UNKNOWN, the first legal code enters its state without a sequence check.
REQ-014 Legal transitions SHALL be GREEN->YELLOW, YELLOW->RED, RED->GREEN, and self-loops.
- Any other transition (e.g. GREEN->RED, RED->YELLOW, YELLOW->GREEN) sets seq.
- The FSM still moves to the sampled state.
REQ-015 The dwell counter SHALL load 1 on state entry, increment per cycle in the same state, and saturate at 2^CNT_W-1.
REQ-016 A YELLOW->RED transition with yellow dwell < YEL_MIN SHALL set yel.
- Exactly YEL_MIN is legal.
REQ-017 conflict SHALL be set in any cycle where either condition holds:
- S is non-red while any of M1, M2 or MT is non-red.
- MT is non-red while M2 is non-red.
REQ-018 cycle_cnt SHALL increment on every M1 RED->GREEN transition and wrap from 16'hFFFF to 0.
- The UNKNOWN->GREEN entry does not count.
REQ-019 Multiple events in one cycle SHALL set all corresponding bits, with a single err_pulse.
REQ-020 clr SHALL zero err_sticky on the next edge.
- An event sampled on that same edge wins: its bit is set.
REQ-021 err_pulse SHALL NOT depend on clr.

Reset
REQ-022 While rst=0 at a rising edge, the block SHALL reset as follows:
- err_sticky = 0, err_pulse = 0, cycle_cnt = 0.
- All road FSMs = UNKNOWN, all dwell counters = 0.
REQ-023 Reset asserted mid-operation SHALL discard all history; checking resumes from UNKNOWN on the first edge after rst returns to 1.

Configuration
REQ-024 Macro TLM_STARVE_CHECK_EN SHALL control the starvation check.
- Defined: a road whose red dwell reaches MAX_RED sets starve, once per red run.
- Undefined: starve logic is absent, err_sticky[4] is tied to 0, and MAX_RED is unused.

Verification
REQ-025 Legal sequence: M1 G(10) -> Y(3) -> R, while S R -> G -> Y(3) -> R, with MT and M2 held red for the whole run; on M1 returning to G -> cycle_cnt=1, err_sticky=5'b00000, err_pulse never high.
REQ-026 M1 Y for 2 cycles then R (YEL_MIN=3) -> err_sticky[2]=1 and a single err_pulse in the cycle after the R sample.
REQ-027 M2=001 and S=001 simultaneously -> err_sticky[1]=1; the same cycle with light_MT=3'b011 also sets err_sticky[0], with one err_pulse.
REQ-028 M1 G->R directly -> err_sticky[3]=1; then clr=1 with no event -> err_sticky=0; then clr=1 on the same edge as a new GREEN->RED sample -> err_sticky[3]=1.
REQ-029 With TLM_STARVE_CHECK_EN defined and MAX_RED=60: S held red for 60 cycles -> err_sticky[4]=1 exactly one cycle after the 60th red sample. Without the macro -> bit stays 0.
REQ-030 Preload 16'hFFFF M1 cycles, then complete one more -> cycle_cnt=0; then assert rst=0 mid-yellow -> all outputs 0, and the first post-reset sample of M1=R raises no seq.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Watches four traffic-light buses (M1, S, MT, M2), latching encoding, conflict,
// yellow-dwell, sequence and optional starvation errors. Optional feature macro: TLM_STARVE_CHECK_EN.
module traffic_light_monitor #(
    parameter int YEL_MIN = 3,
    parameter int MAX_RED = 60,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_MT,
    input  logic [2:0]  light_M2,
    input  logic        clr,
    output logic [4:0]  err_sticky,
    output logic        err_pulse,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_RED     = 2'd3
    } road_st_t;

    localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};

    // ST_UNKNOWN doubles as the "illegal code" marker for a sampled bus.
    function automatic road_st_t decode_light(input logic [2:0] code);
        road_st_t st;
        case (code)
            3'b100:  st = ST_RED;
            3'b010:  st = ST_YELLOW;
            3'b001:  st = ST_GREEN;
            default: st = ST_UNKNOWN;
        endcase
        return st;
    endfunction

    function automatic logic step_legal(input road_st_t from_st, input road_st_t to_st);
        logic ok;
        case (from_st)
            ST_GREEN:  ok = (to_st == ST_GREEN)  || (to_st == ST_YELLOW);
            ST_YELLOW: ok = (to_st == ST_YELLOW) || (to_st == ST_RED);
            ST_RED:    ok = (to_st == ST_RED)    || (to_st == ST_GREEN);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Road index: 0 = M1, 1 = S, 2 = MT, 3 = M2.
    logic     [3:0][2:0]       bus_s;
    road_st_t [3:0]            sampled_s;
    logic     [3:0]            non_red_s;
    road_st_t [3:0]            state_q;
    road_st_t [3:0]            state_d;
    logic     [3:0][CNT_W-1:0] dwell_q;
    logic     [3:0][CNT_W-1:0] dwell_d;

    logic        ev_enc_s;
    logic        ev_conflict_s;
    logic        ev_yel_s;
    logic        ev_seq_s;
    logic        ev_starve_s;
    logic        m1_cycle_s;
    logic [4:0]  events_s;

    logic [4:0]  err_sticky_q;
    logic [4:0]  err_sticky_d;
    logic        err_pulse_q;
    logic        err_pulse_d;
    logic [15:0] cycle_cnt_q;
    logic [15:0] cycle_cnt_d;

    assign bus_s = {light_M2, light_MT, light_S, light_M1};

`ifndef TLM_STARVE_CHECK_EN
    logic [31:0] unused_max_red_s;
    assign unused_max_red_s = 32'(MAX_RED);
`endif

    // Per-road state tracking, event detection and next-state for the output flops.
    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        sampled_s     = {4{ST_UNKNOWN}};
        non_red_s     = 4'b0000;
        ev_enc_s      = 1'b0;
        ev_conflict_s = 1'b0;
        ev_yel_s      = 1'b0;
        ev_seq_s      = 1'b0;
        ev_starve_s   = 1'b0;
        m1_cycle_s    = 1'b0;

        for (int i = 0; i < 4; i++) begin
            sampled_s[i] = decode_light(bus_s[i]);
            non_red_s[i] = (sampled_s[i] == ST_GREEN) || (sampled_s[i] == ST_YELLOW);
            if (sampled_s[i] == ST_UNKNOWN) begin
                ev_enc_s = 1'b1;
            end else if (state_q[i] == ST_UNKNOWN) begin
                state_d[i] = sampled_s[i];
                dwell_d[i] = DWELL_ONE;
            end else if (sampled_s[i] == state_q[i]) begin
                dwell_d[i] = (dwell_q[i] != DWELL_SAT) ? dwell_q[i] + DWELL_ONE : dwell_q[i];
            end else begin
                ev_seq_s   = ev_seq_s | !step_legal(state_q[i], sampled_s[i]);
                ev_yel_s   = ev_yel_s | ((state_q[i] == ST_YELLOW) && (sampled_s[i] == ST_RED) &&
                                         (32'(dwell_q[i]) < 32'(YEL_MIN)));
                m1_cycle_s = m1_cycle_s | ((i == 0) && (state_q[i] == ST_RED) &&
                                           (sampled_s[i] == ST_GREEN));
                state_d[i] = sampled_s[i];
                dwell_d[i] = DWELL_ONE;
            end
`ifdef TLM_STARVE_CHECK_EN
            // Fires only on the edge where the red dwell first reaches MAX_RED.
            ev_starve_s = ev_starve_s | ((sampled_s[i] == ST_RED) &&
                                         (32'(dwell_d[i]) == 32'(MAX_RED)) &&
                                         ((state_q[i] != ST_RED) || (dwell_q[i] != dwell_d[i])));
`endif
        end

        ev_conflict_s = (non_red_s[1] && (non_red_s[0] || non_red_s[2] || non_red_s[3])) ||
                        (non_red_s[2] && non_red_s[3]);
        events_s      = {ev_starve_s, ev_seq_s, ev_yel_s, ev_conflict_s, ev_enc_s};
        err_pulse_d   = |events_s;
        err_sticky_d  = (clr ? 5'b00000 : err_sticky_q) | events_s;
        cycle_cnt_d   = m1_cycle_s ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
    end

    // State, dwell and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_UNKNOWN;
                dwell_q[i] <= {CNT_W{1'b0}};
            end
            err_sticky_q <= 5'b00000;
            err_pulse_q  <= 1'b0;
            cycle_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            err_sticky_q <= err_sticky_d;
            err_pulse_q  <= err_pulse_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_pulse  = err_pulse_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a colour/run-length model.
module tb_traffic_light_monitor;

    localparam int YEL_MIN = 3;
    localparam int MAX_RED = 60;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  light_M1, light_S, light_MT, light_M2;
    logic        clr;
    logic [4:0]  err_sticky;
    logic        err_pulse;
    logic [15:0] cycle_cnt;

    int total = 0;
    int bad   = 0;
    logic pulse_seen;

    // Model: per road, last legal colour (0 none, 1 G, 2 Y, 3 R) and unbounded run length.
    int          m_color[4];
    int          m_run[4];
    logic [4:0]  exp_sticky;
    logic        exp_pulse;
    logic [15:0] exp_cnt;

    traffic_light_monitor #(.YEL_MIN(YEL_MIN), .MAX_RED(MAX_RED), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_S(light_S), .light_MT(light_MT), .light_M2(light_M2),
        .clr(clr), .err_sticky(err_sticky), .err_pulse(err_pulse), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic int color_of(input logic [2:0] code);
        if (code == 3'b001) return 1;
        if (code == 3'b010) return 2;
        if (code == 3'b100) return 3;
        return 0;
    endfunction

    function automatic int succ(input int c);
        return (c == 3) ? 1 : c + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_color[i] = 0;
            m_run[i]   = 0;
        end
        exp_sticky = 5'd0;
        exp_pulse  = 1'b0;
        exp_cnt    = 16'd0;
    endtask

    task automatic model_step();
        logic [2:0] bus[4];
        logic       nonred[4];
        logic [4:0] ev;
        int         c;
        if (!rst) begin
            model_reset();
            return;
        end
        bus = '{light_M1, light_S, light_MT, light_M2};
        ev  = 5'd0;
        for (int i = 0; i < 4; i++) begin
            c = color_of(bus[i]);
            nonred[i] = (c == 1) || (c == 2);
            if (c == 0) begin
                ev[0] = 1'b1;
            end else if (m_color[i] == 0) begin
                m_color[i] = c;
                m_run[i]   = 1;
            end else if (c == m_color[i]) begin
                m_run[i]++;
            end else begin
                if (c != succ(m_color[i])) ev[3] = 1'b1;
                if (m_color[i] == 2 && c == 3 && m_run[i] < YEL_MIN) ev[2] = 1'b1;
                if (i == 0 && m_color[i] == 3 && c == 1) exp_cnt = exp_cnt + 16'd1;
                m_color[i] = c;
                m_run[i]   = 1;
            end
`ifdef TLM_STARVE_CHECK_EN
            if (c == 3 && m_run[i] == MAX_RED) ev[4] = 1'b1;
`endif
        end
        if ((nonred[1] && (nonred[0] || nonred[2] || nonred[3])) || (nonred[2] && nonred[3]))
            ev[1] = 1'b1;
        exp_pulse  = |ev;
        exp_sticky = (clr ? 5'd0 : exp_sticky) | ev;
    endtask

    // One clock: model advances on the sampling edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (err_pulse) pulse_seen = 1'b1;
        chk("sticky", 32'(err_sticky), 32'(exp_sticky));
        chk("pulse", 32'(err_pulse), 32'(exp_pulse));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_l(input logic [2:0] m1, input logic [2:0] s,
                         input logic [2:0] mt, input logic [2:0] m2);
        light_M1 = m1;
        light_S  = s;
        light_MT = mt;
        light_M2 = m2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        set_l(LR, LR, LR, LR);
        run(2);
        rst = 1'b1;
        pulse_seen = 1'b0;
    endtask

    function automatic logic [2:0] rand_light(input logic [2:0] prev);
        int r;
        if ($urandom_range(3) != 0) return prev;
        r = $urandom_range(15);
        if (r == 0) return 3'($urandom_range(7));
        if (r % 3 == 0) return LR;
        if (r % 3 == 1) return LY;
        return LG;
    endfunction

    initial begin
        logic [4:0] starve_exp;
        model_reset();
        pulse_seen = 1'b0;

        // Reset state
        do_reset();
        chk("reset_sticky", 32'(err_sticky), 32'd0);
        chk("reset_pulse", 32'(err_pulse), 32'd0);
        chk("reset_cnt", 32'(cycle_cnt), 32'd0);

        // Legal run with exact YEL_MIN dwell on both roads
        set_l(LG, LR, LR, LR); run(10);
        set_l(LY, LR, LR, LR); run(3);
        set_l(LR, LR, LR, LR); run(1);
        set_l(LR, LG, LR, LR); run(2);
        set_l(LR, LY, LR, LR); run(3);
        set_l(LR, LR, LR, LR); run(1);
        set_l(LG, LR, LR, LR); run(1);
        chk("legal_cnt", 32'(cycle_cnt), 32'd1);
        chk("legal_sticky", 32'(err_sticky), 32'd0);
        chk("legal_no_pulse", 32'(pulse_seen), 32'd0);

        // Short yellow
        do_reset();
        set_l(LG, LR, LR, LR); run(1);
        set_l(LY, LR, LR, LR); run(2);
        set_l(LR, LR, LR, LR); run(1);
        chk("yel_sticky", 32'(err_sticky), 32'b00100);
        chk("yel_pulse", 32'(err_pulse), 32'd1);
        run(1);
        chk("yel_pulse_single", 32'(err_pulse), 32'd0);

        // Conflict, then conflict together with an illegal MT code
        do_reset();
        set_l(LR, LG, LR, LG); run(1);
        chk("conflict_sticky", 32'(err_sticky), 32'b00010);
        do_reset();
        set_l(LR, LG, 3'b011, LG); run(1);
        chk("conf_enc_sticky", 32'(err_sticky), 32'b00011);
        chk("conf_enc_pulse", 32'(err_pulse), 32'd1);

        // Sequence error, clear, clear colliding with a new event
        do_reset();
        set_l(LG, LR, LR, LR); run(1);
        set_l(LR, LR, LR, LR); run(1);
        chk("seq_sticky", 32'(err_sticky), 32'b01000);
        clr = 1'b1; run(1);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        clr = 1'b0;
        set_l(LG, LR, LR, LR); run(1);
        clr = 1'b1;
        set_l(LR, LR, LR, LR); run(1);
        clr = 1'b0;
        chk("clr_vs_event", 32'(err_sticky), 32'b01000);

        // Starvation threshold
`ifdef TLM_STARVE_CHECK_EN
        starve_exp = 5'b10000;
`else
        starve_exp = 5'b00000;
`endif
        do_reset();
        run(MAX_RED - 1);
        chk("starve_before", 32'(err_sticky), 32'd0);
        run(1);
        chk("starve_at", 32'(err_sticky), 32'(starve_exp));
        run(3);
        chk("starve_once", 32'(err_pulse), 32'd0);

        // Randomized traffic with occasional clr and mid-run resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_l(rand_light(light_M1), rand_light(light_S), rand_light(light_MT), rand_light(light_M2));
            clr = ($urandom_range(15) == 0);
            rst = ($urandom_range(199) != 0);
            tick();
        end
        rst = 1'b1;
        clr = 1'b0;

        // Counter wrap from a preloaded value, then reset mid-yellow
        do_reset();
        force dut.cycle_cnt_q = 16'hFFFF;
        #1;
        release dut.cycle_cnt_q;
        exp_cnt = 16'hFFFF;
        set_l(LR, LR, LR, LR); run(1);
        chk("preload_cnt", 32'(cycle_cnt), 32'hFFFF);
        set_l(LG, LR, LR, LR); run(1);
        chk("wrap_cnt", 32'(cycle_cnt), 32'd0);
        set_l(LY, LR, LR, LR); run(1);
        rst = 1'b0; run(1);
        chk("midrst_sticky", 32'(err_sticky), 32'd0);
        chk("midrst_pulse", 32'(err_pulse), 32'd0);
        chk("midrst_cnt", 32'(cycle_cnt), 32'd0);
        rst = 1'b1;
        set_l(LR, LR, LR, LR); run(1);
        chk("post_rst_noseq", 32'(err_sticky), 32'd0);
        chk("post_rst_pulse", 32'(err_pulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
